// File: rtl/snake_pkg.sv
// snake_pkg: types shared by the snake mover and the player-input FSM.
//   dir_t     - 2-bit direction code (left/right/up/down)
//   state_t   - mover FSM states
//   is_reverse- true when two directions point exactly opposite ways
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_L = 2'b00,
    DIR_R = 2'b01,
    DIR_U = 2'b10,
    DIR_D = 2'b11
  } dir_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DEAD = 2'b10
  } state_t;

  // Opposite directions share the axis bit [1] and differ in the sign bit [0].
  function automatic logic is_reverse(dir_t a, dir_t b);
    return (a[1] == b[1]) && (a[0] != b[0]);
  endfunction

endpackage

// File: rtl/snake_mover_if.sv
// snake_mover_if: control inputs and snake image outputs of the mover.
//   master: drives start/direction/grow, observes head, length, step, dead and segments
//   slave : the mover itself
interface snake_mover_if #(
  parameter int unsigned X_W     = 4,
  parameter int unsigned Y_W     = 4,
  parameter int unsigned MAX_LEN = 16
);
  localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);

  logic                         start;
  logic [1:0]                   direction;
  logic                         grow;
  logic [X_W-1:0]               head_x;
  logic [Y_W-1:0]               head_y;
  logic [LEN_W-1:0]             length;
  logic                         step;
  logic                         dead;
  logic [MAX_LEN-1:0]           seg_valid;
  logic [MAX_LEN*(X_W+Y_W)-1:0] seg_xy;

  modport master (
    output start, direction, grow,
    input  head_x, head_y, length, step, dead, seg_valid, seg_xy
  );

  modport slave (
    input  start, direction, grow,
    output head_x, head_y, length, step, dead, seg_valid, seg_xy
  );

endinterface

// File: rtl/tick_gen.sv
// tick_gen: move-pace divider. Counts 0..DIV-1 while enabled and pulses tick on the
// terminal count, wrapping to 0 the same cycle. Held at 0 when disabled or cleared.
//   clk, rst (async, active-low), en, clr -> tick
module tick_gen #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = en && !clr && (cnt_q == CW'(DIV - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr || !en || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/snake_mover.sv
// snake_mover: steps the snake head one cell per divider tick in the latched direction,
// keeps the body as a shift buffer (seg 0 = head) and detects wall/self collision.
//   clk, rst (async, active-low)
//   bus.start/direction/grow in; bus.head_x/head_y/length/step/dead/seg_valid/seg_xy out
module snake_mover
  import snake_pkg::*;
#(
  parameter int unsigned GRID_W    = 16,
  parameter int unsigned GRID_H    = 12,
  parameter int unsigned X_W       = 4,
  parameter int unsigned Y_W       = 4,
  parameter int unsigned TICK_DIV  = 5_000_000,
  parameter int unsigned MAX_LEN   = 16,
  parameter int unsigned START_LEN = 3,
  parameter int unsigned WRAP      = 0
) (
  input logic          clk,
  input logic          rst,
  snake_mover_if.slave bus
);
  localparam int unsigned LEN_W = $clog2(MAX_LEN + 1);
  localparam int unsigned SEG_W = X_W + Y_W;

  state_t state_q, state_d;
  logic   run, load, tick, do_step, collide, oob, dead;

  dir_t dir_in, new_dir, cur_dir_q, cur_dir_d;

  logic [X_W-1:0]   seg_x_q [MAX_LEN];
  logic [X_W-1:0]   seg_x_d [MAX_LEN];
  logic [Y_W-1:0]   seg_y_q [MAX_LEN];
  logic [Y_W-1:0]   seg_y_d [MAX_LEN];
  logic [X_W-1:0]   nx;
  logic [Y_W-1:0]   ny;
  logic [LEN_W-1:0] length_q, length_d;
  logic             grow_pend_q, grow_pend_d;
  logic             step_q;
  logic [MAX_LEN-1:0] hit;

  tick_gen #(
    .DIV (TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (run),
    .clr  (load),
    .tick (tick)
  );

  // FSM: state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_RUN;
      S_RUN:   if (tick && collide) state_d = S_DEAD;
      S_DEAD:  if (bus.start) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs / datapath enables
  always_comb begin
    run     = (state_q == S_RUN);
    dead    = (state_q == S_DEAD);
    load    = bus.start && ((state_q == S_IDLE) || (state_q == S_DEAD));
    do_step = run && tick && !collide;
  end

  // Direction latch: an exact reversal would fold the snake onto itself, so it is dropped.
  assign dir_in  = dir_t'(bus.direction);
  assign new_dir = is_reverse(dir_in, cur_dir_q) ? cur_dir_q : dir_in;

  // Candidate head position and edge handling
  always_comb begin
    nx  = seg_x_q[0];
    ny  = seg_y_q[0];
    oob = 1'b0;
    case (new_dir)
      DIR_L: begin
        if (seg_x_q[0] == '0) begin
          nx  = X_W'(GRID_W - 1);
          oob = (WRAP == 0);
        end else begin
          nx = seg_x_q[0] - X_W'(1);
        end
      end
      DIR_R: begin
        if (seg_x_q[0] == X_W'(GRID_W - 1)) begin
          nx  = '0;
          oob = (WRAP == 0);
        end else begin
          nx = seg_x_q[0] + X_W'(1);
        end
      end
      DIR_U: begin
        if (seg_y_q[0] == '0) begin
          ny  = Y_W'(GRID_H - 1);
          oob = (WRAP == 0);
        end else begin
          ny = seg_y_q[0] - Y_W'(1);
        end
      end
      default: begin
        if (seg_y_q[0] == Y_W'(GRID_H - 1)) begin
          ny  = '0;
          oob = (WRAP == 0);
        end else begin
          ny = seg_y_q[0] + Y_W'(1);
        end
      end
    endcase
  end

  // Per-segment self-collision compare and output packing. The tail vacates its cell on a
  // normal step, so it only counts as an obstacle when a grow keeps it in place.
  for (genvar i = 0; i < MAX_LEN; i++) begin : g_seg
    if (i == 0) begin : g_head
      assign hit[i] = 1'b0;
    end else begin : g_body
      logic in_body;
      assign in_body = (LEN_W'(i + 1) < length_q) ||
                       (grow_pend_q && (LEN_W'(i + 1) == length_q));
      assign hit[i]  = in_body && (seg_x_q[i] == nx) && (seg_y_q[i] == ny);
    end
    assign bus.seg_valid[i]              = (LEN_W'(i) < length_q);
    assign bus.seg_xy[i*SEG_W +: SEG_W]  = {seg_x_q[i], seg_y_q[i]};
  end

  assign collide = oob || (|hit);

  // Body shift buffer
  always_comb begin
    for (int i = 0; i < MAX_LEN; i++) begin
      seg_x_d[i] = seg_x_q[i];
      seg_y_d[i] = seg_y_q[i];
    end
    if (load) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x_d[i] = X_W'(int'(GRID_W / 2) - i);
        seg_y_d[i] = Y_W'(GRID_H / 2);
      end
    end else if (do_step) begin
      seg_x_d[0] = nx;
      seg_y_d[0] = ny;
      for (int i = 1; i < MAX_LEN; i++) begin
        seg_x_d[i] = seg_x_q[i-1];
        seg_y_d[i] = seg_y_q[i-1];
      end
    end
  end

  // Length, pending grow and current direction
  always_comb begin
    length_d    = length_q;
    grow_pend_d = grow_pend_q;
    cur_dir_d   = cur_dir_q;
    if (load) begin
      length_d    = LEN_W'(START_LEN);
      grow_pend_d = 1'b0;
      cur_dir_d   = DIR_R;
    end else if (run) begin
      if (do_step) begin
        cur_dir_d = new_dir;
        // A grow landing in the step cycle is kept for the following step.
        grow_pend_d = bus.grow;
        if (grow_pend_q && (length_q < LEN_W'(MAX_LEN))) begin
          length_d = length_q + LEN_W'(1);
        end
      end else begin
        grow_pend_d = grow_pend_q | bus.grow;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x_q[i] <= X_W'(int'(GRID_W / 2) - i);
        seg_y_q[i] <= Y_W'(GRID_H / 2);
      end
      length_q    <= LEN_W'(START_LEN);
      grow_pend_q <= 1'b0;
      cur_dir_q   <= DIR_R;
      step_q      <= 1'b0;
    end else begin
      seg_x_q     <= seg_x_d;
      seg_y_q     <= seg_y_d;
      length_q    <= length_d;
      grow_pend_q <= grow_pend_d;
      cur_dir_q   <= cur_dir_d;
      step_q      <= do_step;
    end
  end

  assign bus.head_x = seg_x_q[0];
  assign bus.head_y = seg_y_q[0];
  assign bus.length = length_q;
  assign bus.step   = step_q;
  assign bus.dead   = dead;

endmodule

// File: tb/tb_snake_mover.sv
// tb_snake_mover: directed bench for snake_mover. Two instances share the stimulus, one
// with edge death (WRAP=0) and one with wrap-around (WRAP=1); TICK_DIV=4, 16x12 grid,
// MAX_LEN=8, START_LEN=3. Segment values are read as 8'hXY = {x, y}.
module tb_snake_mover;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       grow = 1'b0;
  logic [1:0] direction = 2'b01;

  int checks = 0;
  int errors = 0;

  snake_mover_if #(.X_W(4), .Y_W(4), .MAX_LEN(8)) b0 ();
  snake_mover_if #(.X_W(4), .Y_W(4), .MAX_LEN(8)) b1 ();

  assign b0.start     = start;
  assign b0.direction = direction;
  assign b0.grow      = grow;
  assign b1.start     = start;
  assign b1.direction = direction;
  assign b1.grow      = grow;

  snake_mover #(
    .GRID_W(16), .GRID_H(12), .X_W(4), .Y_W(4), .TICK_DIV(4),
    .MAX_LEN(8), .START_LEN(3), .WRAP(0)
  ) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (b0)
  );

  snake_mover #(
    .GRID_W(16), .GRID_H(12), .X_W(4), .Y_W(4), .TICK_DIV(4),
    .MAX_LEN(8), .START_LEN(3), .WRAP(1)
  ) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (b1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic clk_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for a step pulse on the chosen instance.
  task automatic wait_step(input int which);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin
      @(posedge clk);
      #1;
      seen = (which == 0) ? b0.step : b1.step;
    end
    check("step_seen", 32'(seen), 32'd1);
  endtask

  task automatic restart();
    rst = 1'b0;
    clk_n(1);
    rst = 1'b1;
    start = 1'b1;
    clk_n(1);
    start = 1'b0;
  endtask

  int nsteps;
  bit got_dead;

  initial begin
    // Reset image
    rst = 1'b0;
    clk_n(2);
    check("rst_head_x", 32'(b0.head_x), 32'd8);
    check("rst_head_y", 32'(b0.head_y), 32'd6);
    check("rst_length", 32'(b0.length), 32'd3);
    check("rst_dead", 32'(b0.dead), 32'd0);
    check("rst_step", 32'(b0.step), 32'd0);
    check("rst_seg_valid", 32'(b0.seg_valid), 32'h07);
    check("rst_seg2", 32'(b0.seg_xy[23:16]), 32'h66);
    rst = 1'b1;

    // IDLE: no motion
    nsteps = 0;
    repeat (20) begin
      clk_n(1);
      if (b0.step) nsteps++;
    end
    check("idle_no_step", 32'(nsteps), 32'd0);
    check("idle_head_x", 32'(b0.head_x), 32'd8);

    // Start, then first step exactly on the 5th edge after start is raised
    direction = 2'b01;
    start = 1'b1;
    clk_n(1);
    start = 1'b0;
    check("run_dead", 32'(b0.dead), 32'd0);
    clk_n(3);
    check("first_step_early", 32'(b0.step), 32'd0);
    check("pre_step_head_x", 32'(b0.head_x), 32'd8);
    clk_n(1);
    check("first_step", 32'(b0.step), 32'd1);
    check("step1_head", 32'(b0.seg_xy[7:0]), 32'h96);
    check("step1_seg1", 32'(b0.seg_xy[15:8]), 32'h86);
    clk_n(3);
    check("between_steps", 32'(b0.step), 32'd0);
    // start while running must be ignored; it lands on the next step edge
    start = 1'b1;
    clk_n(1);
    start = 1'b0;
    check("second_step_spacing", 32'(b0.step), 32'd1);
    check("step2_head", 32'(b0.seg_xy[7:0]), 32'hA6);
    check("step2_seg1", 32'(b0.seg_xy[15:8]), 32'h96);
    check("step2_seg2", 32'(b0.seg_xy[23:16]), 32'h86);
    clk_n(1);
    check("step_one_cycle", 32'(b0.step), 32'd0);

    // Reversal ignored, then a turn upward
    direction = 2'b00;
    wait_step(0);
    check("reverse_head_x", 32'(b0.head_x), 32'd11);
    check("reverse_head_y", 32'(b0.head_y), 32'd6);
    direction = 2'b10;
    wait_step(0);
    check("up_head", 32'(b0.seg_xy[7:0]), 32'hB5);
    check("up_seg1", 32'(b0.seg_xy[15:8]), 32'hB6);

    // Wall: death without wrap, wrap-around with WRAP=1
    direction = 2'b01;
    restart();
    repeat (7) wait_step(1);
    check("edge_head_x0", 32'(b0.head_x), 32'd15);
    check("edge_head_x1", 32'(b1.head_x), 32'd15);
    wait_step(1);
    check("wrap_head_x", 32'(b1.head_x), 32'd0);
    check("wrap_head_y", 32'(b1.head_y), 32'd6);
    check("wrap_dead", 32'(b1.dead), 32'd0);
    check("wall_dead", 32'(b0.dead), 32'd1);
    check("wall_head_x", 32'(b0.head_x), 32'd15);
    check("wall_no_step", 32'(b0.step), 32'd0);
    clk_n(8);
    check("dead_frozen_x", 32'(b0.head_x), 32'd15);
    check("dead_held", 32'(b0.dead), 32'd1);

    // Grow: three merged pulses give one segment
    direction = 2'b01;
    restart();
    grow = 1'b1;
    clk_n(3);
    grow = 1'b0;
    wait_step(0);
    check("grow_len_4", 32'(b0.length), 32'd4);
    repeat (5) wait_step(0);
    check("grow_len_hold", 32'(b0.length), 32'd4);
    check("grow_head", 32'(b0.seg_xy[7:0]), 32'hE6);
    // Grow in the step cycle applies to the following step
    direction = 2'b11;
    clk_n(3);
    grow = 1'b1;
    clk_n(1);
    grow = 1'b0;
    check("coinc_step", 32'(b0.step), 32'd1);
    check("coinc_len", 32'(b0.length), 32'd4);
    check("coinc_head", 32'(b0.seg_xy[7:0]), 32'hE7);
    wait_step(0);
    check("coinc_len_next", 32'(b0.length), 32'd5);
    check("coinc_valid", 32'(b0.seg_valid), 32'h1F);
    check("coinc_head2", 32'(b0.seg_xy[7:0]), 32'hE8);

    // Self collision: R, U, L turns the head into segment 3
    direction = 2'b01;
    wait_step(0);
    check("loop_r", 32'(b0.seg_xy[7:0]), 32'hF8);
    direction = 2'b10;
    wait_step(0);
    check("loop_u", 32'(b0.seg_xy[7:0]), 32'hF7);
    direction = 2'b00;
    got_dead = 1'b0;
    for (int k = 0; k < 8 && !got_dead; k++) begin
      clk_n(1);
      got_dead = b0.dead;
    end
    check("self_dead", 32'(got_dead), 32'd1);
    check("self_head", 32'(b0.seg_xy[7:0]), 32'hF7);
    check("self_len", 32'(b0.length), 32'd5);
    check("self_no_step", 32'(b0.step), 32'd0);

    // Restart from DEAD
    start = 1'b1;
    clk_n(1);
    start = 1'b0;
    check("restart_dead", 32'(b0.dead), 32'd0);
    check("restart_head", 32'(b0.seg_xy[7:0]), 32'h86);
    check("restart_len", 32'(b0.length), 32'd3);

    // Ten grows along an L path: length saturates at 8
    for (int i = 0; i < 10; i++) begin
      direction = (i < 5) ? 2'b10 : 2'b00;
      grow = 1'b1;
      clk_n(1);
      grow = 1'b0;
      wait_step(0);
    end
    check("sat_len", 32'(b0.length), 32'd8);
    check("sat_valid", 32'(b0.seg_valid), 32'hFF);
    check("sat_head", 32'(b0.seg_xy[7:0]), 32'h31);
    check("sat_seg7", 32'(b0.seg_xy[63:56]), 32'h83);
    check("sat_dead", 32'(b0.dead), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
